// File: rtl/video_timing_pkg.sv
// Shared widths, timing record and helpers for the cascaded-counter raster timing controller.
package video_timing_pkg;

  localparam int CNT_W   = 12;
  localparam int STAGES  = 3;
  localparam int NIB_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  typedef logic [CNT_W-1:0] pos_t;
  typedef logic [CNT_W:0]   posx_t;

  // One extra bit so a TOTAL or SYNC_END of 4096 stays representable.
  typedef struct packed {
    posx_t total;
    posx_t blank_start;
    posx_t sync_start;
    posx_t sync_end;
  } timing_t;

  typedef struct packed {
    logic blank;
    logic sync_n;
    logic last;
  } decode_t;

  function automatic pos_t preset(input int total);
    return pos_t'(CNT_MOD - total);
  endfunction

  function automatic bit timing_ok(input int total, input int blank_start,
                                   input int sync_start, input int sync_end);
    return (total >= 2) && (total <= CNT_MOD) &&
           (blank_start >= 0) && (blank_start < total) &&
           (sync_start >= 0) && (sync_start < sync_end) && (sync_end <= total);
  endfunction

  function automatic timing_t make_timing(input int total, input int blank_start,
                                          input int sync_start, input int sync_end);
    timing_t t;
    t.total       = posx_t'(total);
    t.blank_start = posx_t'(blank_start);
    t.sync_start  = posx_t'(sync_start);
    t.sync_end    = posx_t'(sync_end);
    return t;
  endfunction

  function automatic decode_t decode(input pos_t pos, input timing_t t);
    decode_t d;
    posx_t   p;
    p        = {1'b0, pos};
    d.blank  = (p >= t.blank_start);
    d.sync_n = !((p >= t.sync_start) && (p < t.sync_end));
    d.last   = (p == t.total - posx_t'(1));
    return d;
  endfunction

endpackage

// File: rtl/video_timing_seq_cnt4_stage.sv
// 4-bit synchronous loadable binary counter stage; clear beats load beats count.
module cnt4_stage
  import video_timing_pkg::*;
(
  input  logic             clk,
  input  logic             _clear,
  input  logic             _load,
  input  logic             en,
  input  logic [NIB_W-1:0] d,
  output logic [NIB_W-1:0] q,
  output logic             rco
);

  always_ff @(posedge clk) begin
    if (!_clear) begin
      q <= '0;
    end else if (!_load) begin
      q <= d;
    end else if (en) begin
      q <= q + NIB_W'(1);
    end
  end

  assign rco = &q;

endmodule

// File: rtl/video_timing_seq.sv
// Raster timing controller: two 3-stage counter chains preset to 4096-TOTAL and decoded to sync/blank.
module video_timing_seq
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL       = 320,
  parameter int H_BLANK_START = 256,
  parameter int H_SYNC_START  = 272,
  parameter int H_SYNC_END    = 304,
  parameter int V_TOTAL       = 262,
  parameter int V_BLANK_START = 224,
  parameter int V_SYNC_START  = 240,
  parameter int V_SYNC_END    = 243
) (
  input  logic             clk,
  input  logic             _reset,
  input  logic             ce,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             line_end,
  output logic             frame_end
);

  localparam pos_t    H_PRESET = preset(H_TOTAL);
  localparam pos_t    V_PRESET = preset(V_TOTAL);
  localparam timing_t H_CFG    = make_timing(H_TOTAL, H_BLANK_START, H_SYNC_START, H_SYNC_END);
  localparam timing_t V_CFG    = make_timing(V_TOTAL, V_BLANK_START, V_SYNC_START, V_SYNC_END);

  if (!timing_ok(H_TOTAL, H_BLANK_START, H_SYNC_START, H_SYNC_END)) begin : g_bad_h
    $fatal(1, "video_timing_seq: illegal horizontal timing parameters");
  end
  if (!timing_ok(V_TOTAL, V_BLANK_START, V_SYNC_START, V_SYNC_END)) begin : g_bad_v
    $fatal(1, "video_timing_seq: illegal vertical timing parameters");
  end

  pos_t              h_raw, v_raw;
  logic [STAGES-1:0] h_rco, v_rco, h_en, v_en;
  logic              h_term, v_term, h_load_n, v_load_n;
  decode_t           h_dec, v_dec;

  // Reset reuses the preset load path, so the chains restart at position 0.
  always_comb begin
    h_term   = &h_rco;
    v_term   = &v_rco;
    h_en     = '0;
    v_en     = '0;
    h_en[0]  = ce;
    v_en[0]  = ce & h_term;
    for (int k = 1; k < STAGES; k++) begin
      h_en[k] = h_en[k-1] & h_rco[k-1];
      v_en[k] = v_en[k-1] & v_rco[k-1];
    end
    h_load_n = _reset & ~(ce & h_term);
    v_load_n = _reset & ~(ce & h_term & v_term);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cnt4_stage u_h (
      .clk    (clk),
      ._clear (1'b1),
      ._load  (h_load_n),
      .en     (h_en[k]),
      .d      (H_PRESET[k*NIB_W +: NIB_W]),
      .q      (h_raw[k*NIB_W +: NIB_W]),
      .rco    (h_rco[k])
    );
    cnt4_stage u_v (
      .clk    (clk),
      ._clear (1'b1),
      ._load  (v_load_n),
      .en     (v_en[k]),
      .d      (V_PRESET[k*NIB_W +: NIB_W]),
      .q      (v_raw[k*NIB_W +: NIB_W]),
      .rco    (v_rco[k])
    );
  end

  assign hpos      = h_raw - H_PRESET;
  assign vpos      = v_raw - V_PRESET;
  assign h_dec     = decode(hpos, H_CFG);
  assign v_dec     = decode(vpos, V_CFG);
  assign hblank    = h_dec.blank;
  assign vblank    = v_dec.blank;
  assign hsync_n   = h_dec.sync_n;
  assign vsync_n   = v_dec.sync_n;
  assign line_end  = h_dec.last;
  assign frame_end = h_dec.last & v_dec.last;

endmodule

// File: tb/tb_video_timing_seq.sv
// Bench for video_timing_seq: four differently-sized rasters share clk/ce/_reset and track a position model.
module tb_video_timing_seq;

  localparam int N = 4;
  localparam int HT  [N] = '{320, 4096, 2, 21};
  localparam int HB  [N] = '{256, 3000, 1, 16};
  localparam int HSS [N] = '{272, 3100, 1, 17};
  localparam int HSE [N] = '{304, 3200, 2, 19};
  localparam int VT  [N] = '{262,  262, 4, 13};
  localparam int VB  [N] = '{224,  224, 2, 10};
  localparam int VSS [N] = '{240,  240, 2, 11};
  localparam int VSE [N] = '{243,  243, 3, 12};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic [11:0] hpos_w [N];
  logic [11:0] vpos_w [N];
  logic        hblank_w [N];
  logic        vblank_w [N];
  logic        hsync_n_w [N];
  logic        vsync_n_w [N];
  logic        line_end_w [N];
  logic        frame_end_w [N];
  logic [29:0] got [N];

  int total = 0;
  int bad = 0;
  int hm [N] = '{0, 0, 0, 0};
  int vm [N] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    video_timing_seq #(
      .H_TOTAL(HT[g]), .H_BLANK_START(HB[g]), .H_SYNC_START(HSS[g]), .H_SYNC_END(HSE[g]),
      .V_TOTAL(VT[g]), .V_BLANK_START(VB[g]), .V_SYNC_START(VSS[g]), .V_SYNC_END(VSE[g])
    ) dut (
      .clk       (clk),
      ._reset    (rst_n),
      .ce        (ce),
      .hpos      (hpos_w[g]),
      .vpos      (vpos_w[g]),
      .hblank    (hblank_w[g]),
      .vblank    (vblank_w[g]),
      .hsync_n   (hsync_n_w[g]),
      .vsync_n   (vsync_n_w[g]),
      .line_end  (line_end_w[g]),
      .frame_end (frame_end_w[g])
    );
    assign got[g] = {hpos_w[g], vpos_w[g], hblank_w[g], vblank_w[g],
                     hsync_n_w[g], vsync_n_w[g], line_end_w[g], frame_end_w[g]};
  end

  // Reference raster: a plain (line, pixel) position advanced once per enabled clock.
  function automatic logic [29:0] expv(input int i);
    int   h, v;
    logic le;
    h  = hm[i];
    v  = vm[i];
    le = (h == HT[i] - 1);
    return {12'(h), 12'(v), 1'(h >= HB[i]), 1'(v >= VB[i]),
            1'(!(h >= HSS[i] && h < HSE[i])), 1'(!(v >= VSS[i] && v < VSE[i])),
            le, 1'(le && v == VT[i] - 1)};
  endfunction

  // mode 0: ce low, 1: ce high, 2: ce random (75% high)
  task automatic step(input int mode);
    ce = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        hm[i] = 0;
        vm[i] = 0;
      end else if (ce) begin
        if (hm[i] == HT[i] - 1) begin
          hm[i] = 0;
          vm[i] = (vm[i] == VT[i] - 1) ? 0 : vm[i] + 1;
        end else begin
          hm[i] = hm[i] + 1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(1);
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== expv(i)) begin bad++; $display("[TB] FAIL reset_state inst=%0d got=%h want=%h", i, got[i], expv(i)); end
      end
    end
    total++;
    if (got[0] !== {12'd0, 12'd0, 6'b001100}) begin
      bad++; $display("[TB] FAIL reset_const got=%h want=%h", got[0], {12'd0, 12'd0, 6'b001100});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 256; c++) begin
      step(1);
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== expv(i)) begin bad++; $display("[TB] FAIL first_count inst=%0d got=%h want=%h", i, got[i], expv(i)); end
      end
    end
    total++;
    if (hpos_w[0] !== 12'd256 || hblank_w[0] !== 1'b1) begin
      bad++; $display("[TB] FAIL first_256 got hpos=%0d hblank=%b want hpos=256 hblank=1", hpos_w[0], hblank_w[0]);
    end
  endtask

  task automatic test_hsync();
    int   fall_pos, rise_pos, width;
    bit   fell, rose;
    logic prev;
    fell = 0; rose = 0; width = 0; fall_pos = -1; rise_pos = -1;
    prev = hsync_n_w[0];
    for (int c = 0; c < 1000 && !rose; c++) begin
      step(2);
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== expv(i)) begin bad++; $display("[TB] FAIL hsync_track inst=%0d got=%h want=%h", i, got[i], expv(i)); end
      end
      if (fell && ce) width++;
      if (!fell && prev && !hsync_n_w[0]) begin
        fell = 1; fall_pos = int'(hpos_w[0]);
      end else if (fell && !prev && hsync_n_w[0]) begin
        rose = 1; rise_pos = int'(hpos_w[0]);
      end
      prev = hsync_n_w[0];
    end
    total++;
    if (!rose) begin bad++; $display("[TB] FAIL hsync_timeout got fell=%0d rose=%0d want both 1", fell, rose); end
    total++;
    if (fall_pos != HSS[0]) begin bad++; $display("[TB] FAIL hsync_fall got=%0d want=%0d", fall_pos, HSS[0]); end
    total++;
    if (rise_pos != HSE[0]) begin bad++; $display("[TB] FAIL hsync_rise got=%0d want=%0d", rise_pos, HSE[0]); end
    total++;
    if (width != HSE[0] - HSS[0]) begin bad++; $display("[TB] FAIL hsync_width got=%0d want=%0d", width, HSE[0] - HSS[0]); end
  endtask

  task automatic test_line_wrap();
    int n;
    bit seen;
    seen = 0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      step(2);
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== expv(i)) begin bad++; $display("[TB] FAIL line_track inst=%0d got=%h want=%h", i, got[i], expv(i)); end
      end
      seen = line_end_w[0];
    end
    total++;
    if (!seen || hpos_w[0] !== 12'(HT[0] - 1)) begin
      bad++; $display("[TB] FAIL line_end_pos got seen=%0d hpos=%0d want seen=1 hpos=%0d", seen, hpos_w[0], HT[0] - 1);
    end
    step(1);
    total++;
    if (hpos_w[0] !== 12'd0 || vpos_w[0] !== 12'd1 || line_end_w[0] !== 1'b0) begin
      bad++; $display("[TB] FAIL line_wrap got h=%0d v=%0d le=%b want h=0 v=1 le=0", hpos_w[0], vpos_w[0], line_end_w[0]);
    end
    n = 0; seen = 0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      step(2);
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== expv(i)) begin bad++; $display("[TB] FAIL line_period_track inst=%0d got=%h want=%h", i, got[i], expv(i)); end
      end
      if (ce) n++;
      seen = line_end_w[0];
    end
    total++;
    if (!seen || n + 1 != HT[0]) begin bad++; $display("[TB] FAIL line_period got=%0d want=%0d", n + 1, HT[0]); end
  endtask

  task automatic test_frame_wrap();
    int n, vs, vbl;
    bit seen;
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      step(2);
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== expv(i)) begin bad++; $display("[TB] FAIL frame_track inst=%0d got=%h want=%h", i, got[i], expv(i)); end
      end
      seen = frame_end_w[3];
    end
    total++;
    if (!seen || hpos_w[3] !== 12'(HT[3] - 1) || vpos_w[3] !== 12'(VT[3] - 1)) begin
      bad++; $display("[TB] FAIL frame_end_pos got seen=%0d h=%0d v=%0d want 1/%0d/%0d", seen, hpos_w[3], vpos_w[3], HT[3] - 1, VT[3] - 1);
    end
    step(1);
    total++;
    if (hpos_w[3] !== 12'd0 || vpos_w[3] !== 12'd0 || frame_end_w[3] !== 1'b0) begin
      bad++; $display("[TB] FAIL frame_wrap got h=%0d v=%0d fe=%b want 0/0/0", hpos_w[3], vpos_w[3], frame_end_w[3]);
    end
    n = 0; seen = 0;
    vs = !vsync_n_w[3] ? 1 : 0;
    vbl = vblank_w[3] ? 1 : 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      step(2);
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== expv(i)) begin bad++; $display("[TB] FAIL frame_period_track inst=%0d got=%h want=%h", i, got[i], expv(i)); end
      end
      if (ce) begin
        n++;
        if (hpos_w[3] == 12'd0) begin
          if (!vsync_n_w[3]) vs++;
          if (vblank_w[3]) vbl++;
        end
      end
      seen = frame_end_w[3];
    end
    total++;
    if (!seen || n + 1 != HT[3] * VT[3]) begin bad++; $display("[TB] FAIL frame_period got=%0d want=%0d", n + 1, HT[3] * VT[3]); end
    total++;
    if (vs != VSE[3] - VSS[3]) begin bad++; $display("[TB] FAIL vsync_lines got=%0d want=%0d", vs, VSE[3] - VSS[3]); end
    total++;
    if (vbl != VT[3] - VB[3]) begin bad++; $display("[TB] FAIL vblank_lines got=%0d want=%0d", vbl, VT[3] - VB[3]); end
  endtask

  task automatic test_stall();
    bit seen;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      step(1);
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== expv(i)) begin bad++; $display("[TB] FAIL stall_approach inst=%0d got=%h want=%h", i, got[i], expv(i)); end
      end
      seen = (hpos_w[0] == 12'd15);
    end
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL stall_reach got hpos=%0d want=15", hpos_w[0]); end
    for (int c = 0; c < 7; c++) begin
      step(0);
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== expv(i)) begin bad++; $display("[TB] FAIL stall_model inst=%0d got=%h want=%h", i, got[i], expv(i)); end
      end
      total++;
      if (got[0] !== {12'd15, 12'd0, 6'b001100}) begin
        bad++; $display("[TB] FAIL stall_hold got=%h want=%h", got[0], {12'd15, 12'd0, 6'b001100});
      end
    end
    step(1);
    total++;
    if (hpos_w[0] !== 12'd16 || vpos_w[0] !== 12'd0) begin
      bad++; $display("[TB] FAIL stall_resume got h=%0d v=%0d want h=16 v=0", hpos_w[0], vpos_w[0]);
    end
  endtask

  task automatic test_edges();
    int n;
    bit seen;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    n = 0; seen = 0;
    for (int c = 0; c < 40000 && !seen; c++) begin
      step(1);
      n++;
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== expv(i)) begin bad++; $display("[TB] FAIL long_run inst=%0d got=%h want=%h", i, got[i], expv(i)); end
      end
      total++;
      if (hpos_w[2] !== 12'(n % 2)) begin bad++; $display("[TB] FAIL h2_toggle got=%0d want=%0d", hpos_w[2], n % 2); end
      if (n == 4095) begin
        total++;
        if (hpos_w[1] !== 12'd4095 || line_end_w[1] !== 1'b1) begin
          bad++; $display("[TB] FAIL wide_last got h=%0d le=%b want h=4095 le=1", hpos_w[1], line_end_w[1]);
        end
      end
      if (n == 4096) begin
        total++;
        if (hpos_w[1] !== 12'd0 || vpos_w[1] !== 12'd1) begin
          bad++; $display("[TB] FAIL wide_wrap got h=%0d v=%0d want h=0 v=1", hpos_w[1], vpos_w[1]);
        end
      end
      seen = (hpos_w[0] == 12'd200 && vpos_w[0] == 12'd100);
    end
    total++;
    if (!seen || n != 100 * HT[0] + 200) begin
      bad++; $display("[TB] FAIL mid_reach got seen=%0d n=%0d want seen=1 n=%0d", seen, n, 100 * HT[0] + 200);
    end
    rst_n = 1'b0;
    step(0);
    for (int i = 0; i < N; i++) begin
      total++;
      if (got[i] !== expv(i)) begin bad++; $display("[TB] FAIL mid_reset_model inst=%0d got=%h want=%h", i, got[i], expv(i)); end
    end
    total++;
    if (got[0] !== {12'd0, 12'd0, 6'b001100}) begin
      bad++; $display("[TB] FAIL mid_reset got=%h want=%h", got[0], {12'd0, 12'd0, 6'b001100});
    end
    rst_n = 1'b1;
    step(0);
    step(0);
    total++;
    if (hpos_w[0] !== 12'd0 || vpos_w[0] !== 12'd0) begin
      bad++; $display("[TB] FAIL release_hold got h=%0d v=%0d want 0/0", hpos_w[0], vpos_w[0]);
    end
    step(1);
    total++;
    if (hpos_w[0] !== 12'd1 || vpos_w[0] !== 12'd0) begin
      bad++; $display("[TB] FAIL release_resume got h=%0d v=%0d want 1/0", hpos_w[0], vpos_w[0]);
    end
  endtask

  initial begin
    $display("[TB] video_timing_seq bench start");
    test_reset();
    test_hsync();
    test_line_wrap();
    test_frame_wrap();
    test_stall();
    test_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
